// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with a registered
// output stage and valid/ready handshakes on every port. A channel is
// chosen either from the `sel` port (manual mode) or by round-robin
// arbitration over the channels that currently present valid data.
// A free-running beat counter records every accepted input beat.
module stream_mux_rr #(
  parameter int WIDTH = 8,   // data width per channel
  parameter int NCH   = 4,   // number of input channels (2..16)
  parameter int SELW  = 2,   // channel index width, 2**SELW >= NCH
  parameter int CNTW  = 16   // beat counter width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch,
  output logic [CNTW-1:0]      beat_cnt
);

  // Selection modes, kept as named values for readability.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Output stage and arbitration state.
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [CNTW-1:0]  beat_cnt_q,  beat_cnt_d;
  logic [SELW-1:0]  rr_last_q,   rr_last_d;

  // Combinational grant information.
  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Round-robin partial scans: channels above rr_last, then the rest.
  logic             rr_hi_vld, rr_lo_vld;
  logic [SELW-1:0]  rr_hi_idx, rr_lo_idx;

  // Output register may load when it is empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Round-robin search: the first valid channel strictly above rr_last wins;
  // if none exists, wrap around to the first valid channel at or below it.
  // Together the two ascending scans give the rr_last+1, rr_last+2, ...
  // modulo-NCH order without any modulo arithmetic.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rr_hi_vld = 1'b0;
    rr_hi_idx = '0;
    rr_lo_vld = 1'b0;
    rr_lo_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!rr_hi_vld && in_valid[k] && (SELW'(k) > rr_last_q)) begin
        rr_hi_vld = 1'b1;
        rr_hi_idx = SELW'(k);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (!rr_lo_vld && in_valid[k] && (SELW'(k) <= rr_last_q)) begin
        rr_lo_vld = 1'b1;
        rr_lo_idx = SELW'(k);
      end
    end
  end

  // Grant selection for the current cycle, depending on the active mode.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode_e'(mode) == MODE_MANUAL) begin
      // A sel value that names no existing channel never matches, so an
      // out-of-range select simply produces no grant.
      for (int k = 0; k < NCH; k++) begin
        if ((int'(sel) == k) && in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(k);
        end
      end
    end else begin
      if (rr_hi_vld) begin
        grant_vld = 1'b1;
        grant_idx = rr_hi_idx;
      end else if (rr_lo_vld) begin
        grant_vld = 1'b1;
        grant_idx = rr_lo_idx;
      end
    end
  end

  // Data multiplexer: pick the granted channel's word out of the flat bus.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == SELW'(k)) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel, and only when the output can load.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = load_en && grant_vld && (grant_idx == SELW'(k));
    end
  end

  // A handshake completes on the granted channel whenever it is ready.
  assign xfer = load_en && grant_vld;

  // Next-state computation for the output stage, counter and arbiter pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    beat_cnt_d  = beat_cnt_q;
    rr_last_d   = rr_last_q;
    if (load_en) begin
      if (grant_vld) begin
        out_data_d  = grant_data;
        out_ch_d    = grant_idx;
        out_valid_d = 1'b1;
        // Counter wraps naturally at its width.
        beat_cnt_d  = beat_cnt_q + CNTW'(1);
        // Manual mode must not disturb the round-robin position.
        if (mode_e'(mode) == MODE_RR) begin
          rr_last_d = grant_idx;
        end
      end else begin
        // Drained with nothing to replace it: data and channel keep their
        // last values, only valid drops.
        out_valid_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset that overrides any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      // NOTE: the datapath registers are reset too because the output data
      // and channel index are architecturally visible as zero after reset.
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      beat_cnt_q  <= '0;
      // Pointing at the last channel gives channel 0 top priority.
      rr_last_q   <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_last_q   <= rr_last_d;
    end
  end

  // Registered outputs.
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (4 channels, 8-bit data). The beat
// counter is narrowed to 5 bits so its wrap-around is reachable quickly.
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int CNTW  = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;
  logic [CNTW-1:0]      beat_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [CNTW-1:0] exp_cnt;

  stream_mux_rr #(
    .WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_chk++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
    n_chk++; if (beat_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", beat_cnt); end
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
    exp_cnt = '0;
  endtask

  task automatic test_manual();
    logic [1:0] sels [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [7:0] exps [4] = '{8'h01, 8'h11, 8'h00, 8'h10};
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {8'h11, 8'h10, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      #1;
      n_chk++; if (in_ready !== (4'b0001 << sels[i])) begin n_fail++; $display("FAIL manual_ready[%0d]: got %b expected %b", i, in_ready, 4'b0001 << sels[i]); end
      tick();
      exp_cnt = exp_cnt + 5'd1;
      n_chk++; if (out_data !== exps[i]) begin n_fail++; $display("FAIL manual_data[%0d]: got %h expected %h", i, out_data, exps[i]); end
      n_chk++; if (out_ch !== sels[i]) begin n_fail++; $display("FAIL manual_ch[%0d]: got %0d expected %0d", i, out_ch, sels[i]); end
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL manual_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    n_chk++; if (beat_cnt !== 5'd4) begin n_fail++; $display("FAIL manual_cnt: got %0d expected 4", beat_cnt); end
  endtask

  // Manual mode left rr_last at its reset value, so channel 0 goes first.
  task automatic test_rr_all();
    logic [1:0] ch;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h11, 8'h10, 8'h01, 8'h00};
    for (int i = 0; i < 6; i++) begin
      ch = 2'(i % 4);
      #1;
      n_chk++; if (in_ready !== (4'b0001 << ch)) begin n_fail++; $display("FAIL rr_all_ready[%0d]: got %b expected %b", i, in_ready, 4'b0001 << ch); end
      tick();
      exp_cnt = exp_cnt + 5'd1;
      n_chk++; if (out_ch !== ch) begin n_fail++; $display("FAIL rr_all_ch[%0d]: got %0d expected %0d", i, out_ch, ch); end
      n_chk++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL rr_all_cnt[%0d]: got %0d expected %0d", i, beat_cnt, exp_cnt); end
    end
  endtask

  // Last grant was channel 1, so channel 3 is next, then alternation.
  task automatic test_rr_sparse();
    logic [7:0] exps [4] = '{8'hcc, 8'h1a, 8'hcc, 8'h1a};
    logic [3:0] rdys [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    in_valid = 4'b1010;
    in_data = {8'hcc, 8'h77, 8'h1a, 8'h55};
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (in_ready !== rdys[i]) begin n_fail++; $display("FAIL rr_sparse_ready[%0d]: got %b expected %b", i, in_ready, rdys[i]); end
      tick();
      exp_cnt = exp_cnt + 5'd1;
      n_chk++; if (out_data !== exps[i]) begin n_fail++; $display("FAIL rr_sparse_data[%0d]: got %h expected %h", i, out_data, exps[i]); end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h11, 8'h10, 8'h01, 8'hef};
    tick();
    exp_cnt = exp_cnt + 5'd1;
    n_chk++; if (out_data !== 8'hef) begin n_fail++; $display("FAIL bp_load: got %h expected ef", out_data); end
    // Stall; changing sel and the channel data must not touch the held beat.
    out_ready = 1'b0; sel = 2'd2;
    in_data = {8'h11, 8'h10, 8'h01, 8'h42};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, in_ready); end
      tick();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      n_chk++; if (out_data !== 8'hef) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected ef", i, out_data); end
      n_chk++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL bp_ch[%0d]: got %0d expected 0", i, out_ch); end
      n_chk++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d expected %0d", i, beat_cnt, exp_cnt); end
    end
    // Release: drain and refill in the same cycle.
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready); end
    tick();
    exp_cnt = exp_cnt + 5'd1;
    n_chk++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL bp_release_data: got %h expected 10", out_data); end
    n_chk++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL bp_release_ch: got %0d expected 2", out_ch); end
    n_chk++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_release_cnt: got %0d expected %0d", beat_cnt, exp_cnt); end
  endtask

  task automatic test_no_grant();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL nogrant_ready[%0d]: got %b expected 0000", i, in_ready); end
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nogrant_valid[%0d]: got %b expected 0", i, out_valid); end
      n_chk++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL nogrant_data[%0d]: got %h expected 10", i, out_data); end
      n_chk++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL nogrant_ch[%0d]: got %0d expected 2", i, out_ch); end
      n_chk++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL nogrant_cnt[%0d]: got %0d expected %0d", i, beat_cnt, exp_cnt); end
    end
    // Empty register loads even with downstream not ready.
    sel = 2'd0; out_ready = 1'b0;
    #1;
    n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL empty_load_ready: got %b expected 0001", in_ready); end
    tick();
    exp_cnt = exp_cnt + 5'd1;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL empty_load_valid: got %b expected 1", out_valid); end
    n_chk++; if (out_data !== 8'h42) begin n_fail++; $display("FAIL empty_load_data: got %h expected 42", out_data); end
  endtask

  // Reset while a stalled beat is held, then check round-robin restarts at 0.
  task automatic test_mid_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", out_data); end
    n_chk++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL midrst_ch: got %0d expected 0", out_ch); end
    n_chk++; if (beat_cnt !== 5'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", beat_cnt); end
    in_valid = 4'b1010; out_ready = 1'b1;
    in_data = {8'h11, 8'h10, 8'h01, 8'h00};
    #1;
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_rr_ready: got %b expected 0010", in_ready); end
    tick();
    exp_cnt = exp_cnt + 5'd1;
    n_chk++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL midrst_rr_ch: got %0d expected 1", out_ch); end
    n_chk++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL midrst_rr_data: got %h expected 01", out_data); end
    n_chk++; if (beat_cnt !== 5'd1) begin n_fail++; $display("FAIL midrst_rr_cnt: got %0d expected 1", beat_cnt); end
  endtask

  // Back-to-back round-robin beats until the 5-bit counter wraps 31 -> 0.
  task automatic test_back_to_back();
    logic [1:0] ch;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      ch = 2'((i + 2) % 4);
      tick();
      exp_cnt = exp_cnt + 5'd1;
      n_chk++; if (out_ch !== ch) begin n_fail++; $display("FAIL b2b_ch[%0d]: got %0d expected %0d", i, out_ch, ch); end
      n_chk++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, beat_cnt, exp_cnt); end
    end
    n_chk++; if (beat_cnt !== 5'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_no_grant();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit stream multiplexer with a registered output stage and a valid/ready handshake on every port. It generalises the team's fixed 4:1 8-bit combinational mux. Two selection modes:
- manual select, driven by the `sel` port;
- round-robin arbitration across the channels that have valid data.

It sits between multiple data producers and a single downstream consumer. It also keeps a running beat counter for debug.

Parameters:
WIDTH, 8, data width per channel in bits
NCH, 4, number of input channels (2..16)
SELW, 2, select/channel-index width; must satisfy 2^SELW >= NCH
CNTW, 16, width of transferred-beat counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
in_data  input  NCH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready (combinational)
sel  input  SELW  channel index used in manual mode
mode  input  1  0 = manual select, 1 = round-robin
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready
out_ch  output  SELW  index of channel that supplied out_data
beat_cnt  output  CNTW  count of accepted input beats

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, beat_cnt=0, rr_last=NCH-1.
  - rr_last = NCH-1 means channel 0 has top priority after reset.
  - Reset takes priority over every other event, including a transfer in the same cycle; a beat held in the output register is discarded.
- load_en = !out_valid || out_ready. The register refills in the same cycle it drains; throughput is 1 beat/cycle.
- Grant, combinational, evaluated every cycle:
  - Manual mode: g = sel. A grant exists only if sel < NCH and in_valid[sel]=1. sel >= NCH means no grant and all in_ready stay 0.
  - Round-robin mode: scan channels rr_last+1, rr_last+2, … modulo NCH. g = first channel with in_valid=1. No grant if all in_valid=0.
- in_ready[k] = load_en && grant exists && k==g. All other in_ready bits are 0.
- in_ready depends on out_ready combinationally; there is no combinational path from in_valid to out_valid.
- Input transfer (handshake on channel g) at a clk edge:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
  - beat_cnt <= beat_cnt + 1. beat_cnt wraps 2^CNTW-1 -> 0.
  - In round-robin mode only, rr_last <= g.
- If load_en=1 and there is no grant, out_valid <= 0. out_data and out_ch hold their last values.
- If out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold; all in_ready are 0.
- Latency: an input accepted at edge n appears on out_data after edge n (one cycle).
- Manual mode never updates rr_last. Switching mode takes effect on the next grant evaluation; the beat already in the output register is unaffected.
- A sel change while the output register is stalled has no effect on the held beat.
- The producer must hold in_valid and in_data until in_ready is seen; the block does not rely on this for correctness.

Test Plan:
- Manual mode, in_data = {8'h11, 8'h10, 8'h01, 8'h00} on ch3..0, all valid, out_ready=1; sel sequence 1, 3, 0, 2.
  -> One cycle later out_data follows 01, 11, 00, 10 with out_ch 1, 3, 0, 2; beat_cnt reaches 4.
- Round-robin mode, all four channels valid continuously, out_ready=1.
  -> out_ch cycles 0, 1, 2, 3, 0, … with one beat/cycle. Exactly one in_ready is high per cycle.
- Round-robin mode, only ch1 and ch3 valid (data 8'h1a, 8'hcc).
  -> out_data alternates 1a, cc, 1a, cc. in_ready[0] and in_ready[2] never assert.
- Backpressure: a beat 8'hef is in the output register and out_ready is held 0 for 3 cycles.
  -> out_valid=1 and out_data=ef stay stable; all in_ready=0; beat_cnt unchanged. On out_ready=1, the next beat loads in the same cycle.
- Manual mode with sel=3, in_valid[3]=0.
  -> out_valid drops to 0 after the current beat drains; no in_ready asserts; beat_cnt frozen.
- Assert rst for 1 cycle mid-stream while out_valid=1 and out_ready=0.
  -> Next cycle out_valid=0, out_data=0, out_ch=0, beat_cnt=0. In round-robin mode the first grant afterwards goes to the lowest-index valid channel.
